sparc_exu_ecl_shftctl: RTL and testbench

SPARC_EXU_ECL_SHFTCTL -- requirements
Module: sparc_exu_ecl_shftctl

---
 rtl/sparc_exu_ecl_shftctl_if.sv | 54 +++++
 rtl/sparc_exu_ecl_shftctl.sv | 93 +++++++++
 tb/tb_sparc_exu_ecl_shftctl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_exu_ecl_shftctl_if.sv
// ----------------------------------------------------------------------------
// sparc_exu_ecl_shftctl_if
// Purpose : bundles every non-clock/reset signal of the shift-control block
//           (D-stage decode inputs, E-stage control/datapath inputs, E-stage
//           shifter control outputs and the registered M-stage result).
// Modports:
//   master - driver side (decode/bypass/datapath): drives D/E inputs,
//            observes the E controls and M result.
//   slave  - the shift-control block itself.
// ----------------------------------------------------------------------------
interface sparc_exu_ecl_shftctl_if;
  // D-stage decode
  logic        ifu_exu_shft_vld_d;
  logic [1:0]  ifu_exu_shft_op_d;
  logic        ifu_exu_shft_op32_d;
  // E-stage pipeline control and data
  logic        ecl_stall_e;
  logic        ecl_flush_e;
  logic [63:0] byp_alu_rs1_data_e;
  logic [3:0]  byp_alu_rs2_data_e;
  logic [63:0] shft_alu_shift_out_e;
  // E-stage shifter controls
  logic        ecl_shft_lshift_e_l;
  logic        ecl_shft_op32_e;
  logic [3:0]  ecl_shft_shift4_e;
  logic [3:0]  ecl_shft_shift1_e;
  logic        ecl_shft_enshift_e_l;
  logic        ecl_shft_extendbit_e;
  logic        ecl_shft_extend32bit_e_l;
  logic        shftctl_vld_e;
  // M-stage result
  logic [63:0] exu_shft_result_m;
  logic        exu_shft_vld_m;

  modport master (
    output ifu_exu_shft_vld_d, ifu_exu_shft_op_d, ifu_exu_shft_op32_d,
           ecl_stall_e, ecl_flush_e, byp_alu_rs1_data_e, byp_alu_rs2_data_e,
           shft_alu_shift_out_e,
    input  ecl_shft_lshift_e_l, ecl_shft_op32_e, ecl_shft_shift4_e,
           ecl_shft_shift1_e, ecl_shft_enshift_e_l, ecl_shft_extendbit_e,
           ecl_shft_extend32bit_e_l, shftctl_vld_e, exu_shft_result_m,
           exu_shft_vld_m
  );

  modport slave (
    input  ifu_exu_shft_vld_d, ifu_exu_shft_op_d, ifu_exu_shft_op32_d,
           ecl_stall_e, ecl_flush_e, byp_alu_rs1_data_e, byp_alu_rs2_data_e,
           shft_alu_shift_out_e,
    output ecl_shft_lshift_e_l, ecl_shft_op32_e, ecl_shft_shift4_e,
           ecl_shft_shift1_e, ecl_shft_enshift_e_l, ecl_shft_extendbit_e,
           ecl_shft_extend32bit_e_l, shftctl_vld_e, exu_shft_result_m,
           exu_shft_vld_m
  );
endinterface

// File: rtl/sparc_exu_ecl_shftctl.sv
// ----------------------------------------------------------------------------
// sparc_exu_ecl_shftctl
// Purpose : shift-unit control for the execute pipeline. Registers the decoded
//           shift (D->E), produces the shifter's combinational E-stage controls
//           (direction, 32/64-bit form, one-hot coarse/fine amount selects,
//           sign-fill bits) and registers the shifter result into M.
// Ports   :
//   rclk   - core clock, all state on rising edge
//   reset  - synchronous active-high reset
//   bus    - sparc_exu_ecl_shftctl_if.slave (D/E inputs, E controls, M result)
// ----------------------------------------------------------------------------
module sparc_exu_ecl_shftctl (
  input  logic                          rclk,
  input  logic                          reset,
  sparc_exu_ecl_shftctl_if.slave        bus
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // E-stage state
  logic        r_vld_e;
  logic [1:0]  r_op_e;
  logic        r_op32_e;
  // M-stage state
  logic        r_vld_m;
  logic [63:0] r_result_m;

  logic        w_advance_e;
  logic        w_sra_e;
  logic        w_sign_e;
  logic        w_unused_rs1;

  // An E instruction moves to M only if it is neither held nor killed.
  assign w_advance_e = r_vld_e & ~bus.ecl_stall_e & ~bus.ecl_flush_e;

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_vld_e    <= 1'b0;
      r_op_e     <= 2'b00;
      r_op32_e   <= 1'b0;
      r_vld_m    <= 1'b0;
      r_result_m <= 64'd0;
    end else begin
      if (!bus.ecl_stall_e) begin
        r_op_e   <= bus.ifu_exu_shft_op_d;
        r_op32_e <= bus.ifu_exu_shft_op32_d;
        // Reserved encoding is accepted into E as a bubble.
        r_vld_e  <= bus.ifu_exu_shft_vld_d & (bus.ifu_exu_shft_op_d != OP_RSV);
      end
      // Flush overrides both load and hold.
      if (bus.ecl_flush_e) begin
        r_vld_e <= 1'b0;
      end
      r_vld_m <= w_advance_e;
      if (w_advance_e) begin
        r_result_m <= bus.shft_alu_shift_out_e;
      end
    end
  end

  // Sign source: bit 31 for the 32-bit form, bit 63 for the 64-bit form.
  assign w_sra_e  = r_vld_e & (r_op_e == OP_SRA);
  assign w_sign_e = r_op32_e ? bus.byp_alu_rs1_data_e[31] : bus.byp_alu_rs1_data_e[63];

  assign bus.shftctl_vld_e            = r_vld_e;
  assign bus.ecl_shft_op32_e          = r_op32_e & r_vld_e;
  assign bus.ecl_shft_enshift_e_l     = ~r_vld_e;
  assign bus.ecl_shft_lshift_e_l      = ~(r_vld_e & (r_op_e == OP_SLL));
  assign bus.ecl_shft_extendbit_e     = w_sra_e & w_sign_e;
  assign bus.ecl_shft_extend32bit_e_l = ~(w_sra_e & r_op32_e & bus.byp_alu_rs1_data_e[31]);

  // One-hot amount selects; an idle E parks both on position 0 so the
  // shifter mux never sees a zero-hot or multi-hot select.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      localparam logic [1:0] IDX = 2'(gi);
      assign bus.ecl_shft_shift4_e[gi] = r_vld_e ? (bus.byp_alu_rs2_data_e[3:2] == IDX)
                                                 : (gi == 0);
      assign bus.ecl_shft_shift1_e[gi] = r_vld_e ? (bus.byp_alu_rs2_data_e[1:0] == IDX)
                                                 : (gi == 0);
    end
  endgenerate

  assign bus.exu_shft_vld_m    = r_vld_m;
  assign bus.exu_shft_result_m = r_result_m;

  // Only the two sign bits of rs1 are consumed here.
  assign w_unused_rs1 = ^{bus.byp_alu_rs1_data_e[62:32], bus.byp_alu_rs1_data_e[30:0]};

endmodule

// File: tb/tb_sparc_exu_ecl_shftctl.sv
// ----------------------------------------------------------------------------
// tb_sparc_exu_ecl_shftctl
// Purpose : self-checking bench for sparc_exu_ecl_shftctl. A transaction-level
//           model (instruction record in E, result slot in M) predicts every
//           output each cycle; directed vectors add hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_sparc_exu_ecl_shftctl;

  logic rclk  = 1'b0;
  logic reset = 1'b1;
  always #5 rclk = ~rclk;

  sparc_exu_ecl_shftctl_if bus ();

  sparc_exu_ecl_shftctl dut (
    .rclk  (rclk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit       vld;
    bit [1:0] op;
    bit       op32;
  } ins_t;

  ins_t      e_slot = '0;
  bit        m_vld  = 1'b0;
  bit [63:0] m_res  = 64'd0;
  bit        armed  = 1'b0;

  always @(posedge rclk) begin
    bit adv;
    if (reset) begin
      e_slot = '0;
      m_vld  = 1'b0;
      m_res  = 64'd0;
      armed  = 1'b1;
    end else begin
      adv   = e_slot.vld && !bus.ecl_stall_e && !bus.ecl_flush_e;
      m_vld = adv;
      if (adv) m_res = bus.shft_alu_shift_out_e;
      if (!bus.ecl_stall_e)
        e_slot = '{vld:  bus.ifu_exu_shft_vld_d && (bus.ifu_exu_shft_op_d != 2'b11),
                   op:   bus.ifu_exu_shft_op_d,
                   op32: bus.ifu_exu_shft_op32_d};
      if (bus.ecl_flush_e) e_slot.vld = 1'b0;
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge rclk) begin
    int amt;
    bit is_sra, sign;
    bit [3:0] x4, x1;
    if (armed) begin
      amt    = int'(bus.byp_alu_rs2_data_e);
      x4     = e_slot.vld ? 4'(1 << (amt / 4)) : 4'd1;
      x1     = e_slot.vld ? 4'(1 << (amt % 4)) : 4'd1;
      is_sra = e_slot.vld && e_slot.op == 2'd2;
      sign   = e_slot.op32 ? bus.byp_alu_rs1_data_e[31] : bus.byp_alu_rs1_data_e[63];
      check("m_vld_e",    bus.shftctl_vld_e,            e_slot.vld);
      check("m_op32_e",   bus.ecl_shft_op32_e,          e_slot.vld && e_slot.op32);
      check("m_enshift",  bus.ecl_shft_enshift_e_l,     !e_slot.vld);
      check("m_lshift",   bus.ecl_shft_lshift_e_l,      !(e_slot.vld && e_slot.op == 2'd0));
      check("m_shift4",   bus.ecl_shft_shift4_e,        x4);
      check("m_shift1",   bus.ecl_shft_shift1_e,        x1);
      check("m_extbit",   bus.ecl_shft_extendbit_e,     is_sra && sign);
      check("m_ext32_l",  bus.ecl_shft_extend32bit_e_l, !(is_sra && e_slot.op32 && bus.byp_alu_rs1_data_e[31]));
      check("m_vld_m",    bus.exu_shft_vld_m,           m_vld);
      check("m_result_m", bus.exu_shft_result_m,        m_res);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rst, input bit vd, input bit [1:0] op, input bit op32,
                     input bit st, input bit fl, input bit [63:0] rs1,
                     input bit [3:0] rs2, input bit [63:0] sh);
    @(posedge rclk);
    #1;
    reset                    = rst;
    bus.ifu_exu_shft_vld_d   = vd;
    bus.ifu_exu_shft_op_d    = op;
    bus.ifu_exu_shft_op32_d  = op32;
    bus.ecl_stall_e          = st;
    bus.ecl_flush_e          = fl;
    bus.byp_alu_rs1_data_e   = rs1;
    bus.byp_alu_rs2_data_e   = rs2;
    bus.shft_alu_shift_out_e = sh;
    @(negedge rclk);
    $display("cyc t=%0t rst=%0b vd=%0b op=%0d op32=%0b st=%0b fl=%0b rs2=%h | vld_e=%0b vld_m=%0b res=%h",
             $time, rst, vd, op, op32, st, fl, rs2,
             bus.shftctl_vld_e, bus.exu_shft_vld_m, bus.exu_shft_result_m);
  endtask

  task automatic idle();
    cyc(0, 0, 2'd0, 0, 0, 0, 64'd0, 4'd0, 64'd0);
  endtask

  initial begin
    bus.ifu_exu_shft_vld_d   = 1'b0;
    bus.ifu_exu_shft_op_d    = 2'd0;
    bus.ifu_exu_shft_op32_d  = 1'b0;
    bus.ecl_stall_e          = 1'b0;
    bus.ecl_flush_e          = 1'b0;
    bus.byp_alu_rs1_data_e   = 64'd0;
    bus.byp_alu_rs2_data_e   = 4'd0;
    bus.shft_alu_shift_out_e = 64'd0;

    // Reset values
    cyc(1, 1, 2'd0, 0, 0, 0, 64'd0, 4'hF, 64'hFFFF);
    cyc(1, 1, 2'd0, 0, 0, 0, 64'd0, 4'hF, 64'hFFFF);
    check("rst_enshift", bus.ecl_shft_enshift_e_l, 1);
    check("rst_lshift",  bus.ecl_shft_lshift_e_l, 1);
    check("rst_shift4",  bus.ecl_shft_shift4_e, 4'b0001);
    check("rst_shift1",  bus.ecl_shft_shift1_e, 4'b0001);
    check("rst_extbit",  bus.ecl_shft_extendbit_e, 0);
    check("rst_ext32_l", bus.ecl_shft_extend32bit_e_l, 1);
    check("rst_vld_e",   bus.shftctl_vld_e, 0);
    check("rst_vld_m",   bus.exu_shft_vld_m, 0);

    // sll 64-bit, count 0xD
    cyc(0, 1, 2'd0, 0, 0, 0, 64'd0, 4'd0, 64'd0);
    cyc(0, 0, 2'd0, 0, 0, 0, 64'd0, 4'hD, 64'hA5A5_0000_1234_5678);
    check("sll_lshift",  bus.ecl_shft_lshift_e_l, 0);
    check("sll_shift4",  bus.ecl_shft_shift4_e, 4'b1000);
    check("sll_shift1",  bus.ecl_shft_shift1_e, 4'b0010);
    check("sll_enshift", bus.ecl_shft_enshift_e_l, 0);
    check("sll_vld_m0",  bus.exu_shft_vld_m, 0);
    idle();
    check("sll_vld_m",   bus.exu_shft_vld_m, 1);
    check("sll_result",  bus.exu_shft_result_m, 64'hA5A5_0000_1234_5678);

    // sra 32-bit with rs1[31]=1 then rs1[31]=0
    cyc(0, 1, 2'd2, 1, 0, 0, 64'd0, 4'd0, 64'd0);
    cyc(0, 1, 2'd2, 1, 0, 0, 64'h0000_0000_8000_0000, 4'd3, 64'h11);
    check("sra32_ext",   bus.ecl_shft_extendbit_e, 1);
    check("sra32_ext32", bus.ecl_shft_extend32bit_e_l, 0);
    check("sra32_op32",  bus.ecl_shft_op32_e, 1);
    check("sra32_lsh",   bus.ecl_shft_lshift_e_l, 1);
    cyc(0, 0, 2'd0, 0, 0, 0, 64'hFFFF_FFFF_7FFF_FFFF, 4'd3, 64'h22);
    check("sra32p_ext",   bus.ecl_shft_extendbit_e, 0);
    check("sra32p_ext32", bus.ecl_shft_extend32bit_e_l, 1);
    check("sra32_b2b_m",  bus.exu_shft_vld_m, 1);
    check("sra32_b2b_r",  bus.exu_shft_result_m, 64'h11);

    // sra 64-bit then srl 64-bit on rs1[63]=1, rs1[31]=0
    cyc(0, 1, 2'd2, 0, 0, 0, 64'd0, 4'd0, 64'h33);
    cyc(0, 1, 2'd1, 0, 0, 0, 64'h8000_0000_0000_0000, 4'd0, 64'h44);
    check("sra64_ext",   bus.ecl_shft_extendbit_e, 1);
    check("sra64_ext32", bus.ecl_shft_extend32bit_e_l, 1);
    check("sra64_op32",  bus.ecl_shft_op32_e, 0);
    cyc(0, 0, 2'd0, 0, 0, 0, 64'h8000_0000_0000_0000, 4'd0, 64'h55);
    check("srl64_ext",   bus.ecl_shft_extendbit_e, 0);
    check("srl64_lsh",   bus.ecl_shft_lshift_e_l, 1);
    idle();
    idle();

    // Valid in E, stall two cycles, then release
    cyc(0, 1, 2'd0, 0, 0, 0, 64'd0, 4'd0, 64'd0);
    cyc(0, 0, 2'd0, 0, 1, 0, 64'd0, 4'd5, 64'hBEEF);
    check("stl1_vld_e",  bus.shftctl_vld_e, 1);
    check("stl1_shift4", bus.ecl_shft_shift4_e, 4'b0010);
    check("stl1_vld_m",  bus.exu_shft_vld_m, 0);
    cyc(0, 0, 2'd0, 0, 1, 0, 64'd0, 4'd5, 64'hBEEF);
    check("stl2_vld_e",  bus.shftctl_vld_e, 1);
    check("stl2_shift1", bus.ecl_shft_shift1_e, 4'b0010);
    check("stl2_vld_m",  bus.exu_shft_vld_m, 0);
    cyc(0, 0, 2'd0, 0, 0, 0, 64'd0, 4'd5, 64'hCAFE);
    check("stl3_vld_e",  bus.shftctl_vld_e, 1);
    check("stl3_vld_m",  bus.exu_shft_vld_m, 0);
    idle();
    check("stl4_vld_e",  bus.shftctl_vld_e, 0);
    check("stl4_vld_m",  bus.exu_shft_vld_m, 1);
    check("stl4_result", bus.exu_shft_result_m, 64'hCAFE);
    idle();
    check("stl5_vld_m",  bus.exu_shft_vld_m, 0);
    check("stl5_hold",   bus.exu_shft_result_m, 64'hCAFE);

    // Stall + flush together, then reserved op
    cyc(0, 1, 2'd1, 0, 0, 0, 64'd0, 4'd0, 64'd0);
    cyc(0, 1, 2'd0, 0, 1, 1, 64'd0, 4'd9, 64'h77);
    check("sf_pre_vld_e", bus.shftctl_vld_e, 1);
    cyc(0, 1, 2'd3, 0, 0, 0, 64'd0, 4'd9, 64'h88);
    check("sf_vld_e",   bus.shftctl_vld_e, 0);
    check("sf_vld_m",   bus.exu_shft_vld_m, 0);
    check("sf_shift4",  bus.ecl_shft_shift4_e, 4'b0001);
    check("sf_shift1",  bus.ecl_shft_shift1_e, 4'b0001);
    idle();
    check("rsv_vld_e",  bus.shftctl_vld_e, 0);

    // Reset pulse with valid E and M
    cyc(0, 1, 2'd2, 0, 0, 0, 64'd0, 4'd0, 64'h99);
    cyc(0, 1, 2'd0, 0, 0, 0, 64'd0, 4'd0, 64'h1234);
    cyc(1, 0, 2'd0, 0, 0, 0, 64'd0, 4'd6, 64'h5678);
    check("rp_pre_vld_e", bus.shftctl_vld_e, 1);
    check("rp_pre_vld_m", bus.exu_shft_vld_m, 1);
    idle();
    check("rp_vld_e",    bus.shftctl_vld_e, 0);
    check("rp_vld_m",    bus.exu_shft_vld_m, 0);
    check("rp_result",   bus.exu_shft_result_m, 64'd0);
    check("rp_enshift",  bus.ecl_shft_enshift_e_l, 1);
    check("rp_ext32",    bus.ecl_shft_extend32bit_e_l, 1);
    idle();
    check("rp_after_m",  bus.exu_shft_vld_m, 0);

    // Mixed traffic; the model checks each cycle
    for (int i = 0; i < 80; i++) begin
      cyc(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
          {$urandom, $urandom}, 4'($urandom), {$urandom, $urandom});
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
